// File: rtl/icache_refill_unit.sv
// -----------------------------------------------------------------------------
// icache_refill_unit
//
// Services instruction-cache line misses. A single-cycle miss pulse latches the
// missing address. The unit then issues one line-sized burst read on the memory
// request channel and collects the returned beats into a line buffer. Once the
// whole line is present it is presented to the icache together with a
// single-cycle refill pulse. Only one miss is outstanding at a time.
//
// Optional feature (compile-time macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN):
//   defined   - the burst starts at the beat that holds the missed PC and wraps
//               modulo BEATS. Every beat is written to its true slot in the line.
//   undefined - the burst starts at beat 0 and the request address is line
//               aligned.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   icache_miss_valid_i      miss request pulse
//   icache_miss_addr_i       missing fetch PC (any byte offset)
//   refill_icache_valid_o    single-cycle refill pulse
//   refill_icache_data_o     assembled line (beat k at [k*BEAT_WIDTH +: BEAT_WIDTH])
//   mem_req_valid_o/ready_i  burst read request handshake
//   mem_req_addr_o           burst start byte address
//   mem_req_len_o            beats minus one (constant)
//   mem_rsp_valid_i/ready_o  response beat handshake
//   mem_rsp_data_i           response beat data
//   mem_rsp_last_i           final beat marker (checked only, not used for completion)
//   busy_o                   a miss is outstanding
//   proto_err_o              sticky protocol-violation flag
// -----------------------------------------------------------------------------
module icache_refill_unit #(
    parameter int ADDR_WIDTH   = 64,
    parameter int LINE_SIZE    = 512,
    parameter int BEAT_WIDTH   = 64,
    parameter int OFFSET_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_miss_valid_i,
    input  logic [ADDR_WIDTH-1:0] icache_miss_addr_i,
    output logic                  refill_icache_valid_o,
    output logic [LINE_SIZE-1:0]  refill_icache_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,
    input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
    input  logic                  mem_rsp_last_i,
    output logic                  busy_o,
    output logic                  proto_err_o
);

    localparam int BEATS = LINE_SIZE / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BOFF  = $clog2(BEAT_WIDTH / 8);

    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_WIDTH) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {IDLE, REQ, BEAT, RESP} state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [CNT_W-1:0]      start_beat_q;
    logic [CNT_W-1:0]      beat_cnt;      // line slot of the next beat
    logic [CNT_W-1:0]      rcv_cnt;       // beats accepted so far in this burst
    logic [LINE_SIZE-1:0]  line_buf;
    logic [LINE_SIZE-1:0]  line_merged;
    logic [LINE_SIZE-1:0]  refill_data_q;
    logic                  proto_err_q;

    logic [ADDR_WIDTH-1:0] miss_req_addr;
    logic [CNT_W-1:0]      miss_start_beat;
    logic                  beat_fire;
    logic                  final_beat;
    logic                  err_set;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK =
        ~((ADDR_WIDTH'(1) << BOFF) - ADDR_WIDTH'(1));
    assign miss_start_beat = icache_miss_addr_i[OFFSET_WIDTH-1:BOFF];
    assign miss_req_addr   = icache_miss_addr_i & BEAT_MASK;
`else
    assign miss_start_beat = '0;
    assign miss_req_addr   = icache_miss_addr_i & LINE_MASK;
`endif

    assign mem_req_addr_o       = req_addr_q;
    assign mem_req_len_o        = 8'(BEATS - 1);
    assign refill_icache_data_o = refill_data_q;
    assign proto_err_o          = proto_err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next            = state;
        mem_req_valid_o       = 1'b0;
        mem_rsp_ready_o       = 1'b0;
        refill_icache_valid_o = 1'b0;
        beat_fire             = 1'b0;
        final_beat            = 1'b0;
        case (state)
            IDLE: begin
                if (icache_miss_valid_i) state_next = REQ;
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_next = BEAT;
            end
            BEAT: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) begin
                    beat_fire = 1'b1;
                    // Completion is counted in beats; mem_rsp_last_i is only checked.
                    if (rcv_cnt == LAST_CNT) begin
                        final_beat = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                refill_icache_valid_o = 1'b1;
                state_next            = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_o = (state != IDLE);

    // Line buffer with the incoming beat dropped into its slot; the final beat's
    // merged line goes straight to the output register so it is never partial.
    always_comb begin
        line_merged = line_buf;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == CNT_W'(k))
                line_merged[k*BEAT_WIDTH +: BEAT_WIDTH] = mem_rsp_data_i;
        end
    end

    always_comb begin
        err_set = 1'b0;
        if (icache_miss_valid_i && busy_o)
            err_set = 1'b1;
        if (mem_rsp_valid_i && (state != BEAT))
            err_set = 1'b1;
        if (beat_fire && (mem_rsp_last_i != (rcv_cnt == LAST_CNT)))
            err_set = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q    <= '0;
            start_beat_q  <= '0;
            beat_cnt      <= '0;
            rcv_cnt       <= '0;
            refill_data_q <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            if ((state == IDLE) && icache_miss_valid_i) begin
                req_addr_q   <= miss_req_addr;
                start_beat_q <= miss_start_beat;
            end
            if ((state == REQ) && mem_req_ready_i) begin
                beat_cnt <= start_beat_q;
                rcv_cnt  <= '0;
            end
            if (beat_fire) begin
                beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + CNT_W'(1);
                rcv_cnt  <= rcv_cnt + CNT_W'(1);
            end
            if (final_beat) refill_data_q <= line_merged;
            if (err_set)    proto_err_q   <= 1'b1;
        end
    end

    // Line storage is pure data and carries no reset.
    always_ff @(posedge clk) begin
        if (beat_fire) line_buf <= line_merged;
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_unit
//
// Self-checking bench for icache_refill_unit. Expected lines are pushed to a
// scoreboard queue as the beats are driven and popped when the refill pulse
// appears. Handles both builds of ICACHE_REFILL_CRITICAL_WORD_FIRST_EN.
// -----------------------------------------------------------------------------
module tb_icache_refill_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         icache_miss_valid_i;
    logic [63:0]  icache_miss_addr_i;
    logic         refill_icache_valid_o;
    logic [511:0] refill_icache_data_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [63:0]  mem_req_addr_o;
    logic [7:0]   mem_req_len_o;
    logic         mem_rsp_valid_i;
    logic         mem_rsp_ready_o;
    logic [63:0]  mem_rsp_data_i;
    logic         mem_rsp_last_i;
    logic         busy_o;
    logic         proto_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] sb[$];
    logic [511:0] mon_exp;
    logic [511:0] last_line = '0;

    icache_refill_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .icache_miss_valid_i   (icache_miss_valid_i),
        .icache_miss_addr_i    (icache_miss_addr_i),
        .refill_icache_valid_o (refill_icache_valid_o),
        .refill_icache_data_o  (refill_icache_data_o),
        .mem_req_valid_o       (mem_req_valid_o),
        .mem_req_ready_i       (mem_req_ready_i),
        .mem_req_addr_o        (mem_req_addr_o),
        .mem_req_len_o         (mem_req_len_o),
        .mem_rsp_valid_i       (mem_rsp_valid_i),
        .mem_rsp_ready_o       (mem_rsp_ready_o),
        .mem_rsp_data_i        (mem_rsp_data_i),
        .mem_rsp_last_i        (mem_rsp_last_i),
        .busy_o                (busy_o),
        .proto_err_o           (proto_err_o)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every refill pulse must match the oldest expected line.
    always @(negedge clk) begin
        if (refill_icache_valid_o) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL refill_unexpected: pulse seen, expected none");
            end else begin
                mon_exp = sb.pop_front();
                if (refill_icache_data_o !== mon_exp) begin
                    n_fail++;
                    $display("FAIL refill_data: got %h expected %h", refill_icache_data_o, mon_exp);
                end
            end
        end
    end

    function automatic logic [63:0] exp_req_addr(input logic [63:0] a);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        return {a[63:3], 3'b000};
`else
        return {a[63:6], 6'b000000};
`endif
    endfunction

    function automatic int exp_start(input logic [63:0] a);
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
        return int'(a[5:3]);
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        icache_miss_valid_i = 1'b0;
        icache_miss_addr_i  = '0;
        mem_req_ready_i     = 1'b0;
        mem_rsp_valid_i     = 1'b0;
        mem_rsp_data_i      = '0;
        mem_rsp_last_i      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Miss pulse at T; request must be visible at T+1.
    task automatic do_miss(input logic [63:0] addr, input string nm);
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = addr;
        tick();
        icache_miss_valid_i = 1'b0;
        icache_miss_addr_i  = 64'h0;
        chk({nm, "_req_valid"}, {63'b0, mem_req_valid_o}, 64'd1);
        chk({nm, "_req_addr"}, mem_req_addr_o, exp_req_addr(addr));
        chk({nm, "_req_len"}, {56'b0, mem_req_len_o}, 64'd7);
    endtask

    task automatic do_req(input int stall, input logic [63:0] exp_addr, input string nm);
        for (int i = 0; i < stall; i++) begin
            chk({nm, "_stall_valid"}, {63'b0, mem_req_valid_o}, 64'd1);
            chk({nm, "_stall_addr"}, mem_req_addr_o, exp_addr);
            chk({nm, "_stall_rsp_ready"}, {63'b0, mem_rsp_ready_o}, 64'd0);
            tick();
        end
        mem_req_ready_i = 1'b1;
        chk({nm, "_hs_valid"}, {63'b0, mem_req_valid_o}, 64'd1);
        chk({nm, "_hs_addr"}, mem_req_addr_o, exp_addr);
        tick();
        mem_req_ready_i = 1'b0;
        chk({nm, "_rsp_ready"}, {63'b0, mem_rsp_ready_o}, 64'd1);
    endtask

    // Drives 8 beats starting at line slot 'start'; gap idle cycles between beats,
    // last_gap idle cycles before the final beat, last marker on beat index last_at,
    // and an illegal miss pulse alongside beat index miss_at (-1: none).
    task automatic do_beats(input int start, input logic [63:0] base, input int gap,
                            input int last_gap, input int last_at, input int miss_at,
                            input string nm);
        logic [511:0] exp;
        int           slot;
        exp = '0;
        for (int i = 0; i < 8; i++) begin
            slot = (start + i) % 8;
            exp[slot*64 +: 64] = base + 64'(slot);
        end
        for (int i = 0; i < 8; i++) begin
            slot = (start + i) % 8;
            if (i > 0) begin
                for (int g = 0; g < ((i == 7) ? last_gap : gap); g++) tick();
            end
            if (i == 7) begin
                chk({nm, "_early_pulse"}, {63'b0, refill_icache_valid_o}, 64'd0);
                sb.push_back(exp);
            end
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = base + 64'(slot);
            mem_rsp_last_i  = (i == last_at);
            if (i == miss_at) begin
                icache_miss_valid_i = 1'b1;
                icache_miss_addr_i  = 64'hDEAD_0000;
            end
            tick();
            mem_rsp_valid_i     = 1'b0;
            mem_rsp_last_i      = 1'b0;
            icache_miss_valid_i = 1'b0;
        end
        chk({nm, "_pulse"}, {63'b0, refill_icache_valid_o}, 64'd1);
        tick();
        chk({nm, "_pulse_done"}, {63'b0, refill_icache_valid_o}, 64'd0);
        chk({nm, "_idle"}, {63'b0, busy_o}, 64'd0);
        n_checks++;
        if (refill_icache_data_o !== exp) begin
            n_fail++;
            $display("FAIL %s_data_held: got %h expected %h", nm, refill_icache_data_o, exp);
        end
        last_line = exp;
    endtask

    task automatic test_reset();
        do_reset();
        chk("rst_refill_valid", {63'b0, refill_icache_valid_o}, 64'd0);
        chk("rst_refill_data", refill_icache_data_o[63:0], 64'd0);
        chk("rst_refill_data_hi", refill_icache_data_o[511:448], 64'd0);
        chk("rst_req_valid", {63'b0, mem_req_valid_o}, 64'd0);
        chk("rst_req_addr", mem_req_addr_o, 64'd0);
        chk("rst_rsp_ready", {63'b0, mem_rsp_ready_o}, 64'd0);
        chk("rst_busy", {63'b0, busy_o}, 64'd0);
        chk("rst_proto_err", {63'b0, proto_err_o}, 64'd0);
    endtask

    task automatic run_miss(input logic [63:0] addr, input int stall, input logic [63:0] base,
                            input int gap, input int last_gap, input int last_at,
                            input int miss_at, input string nm);
        do_miss(addr, nm);
        do_req(stall, exp_req_addr(addr), nm);
        do_beats(exp_start(addr), base, gap, last_gap, last_at, miss_at, nm);
    endtask

    task automatic test_basic();
        run_miss(64'h8000_1234, 0, 64'h1111_0000_0000_0000, 0, 0, 7, -1, "basic");
        chk("basic_err", {63'b0, proto_err_o}, 64'd0);
    endtask

    task automatic test_backpressure();
        icache_miss_valid_i = 1'b1;
        icache_miss_addr_i  = 64'h8000_4040;
        tick();
        icache_miss_valid_i = 1'b0;
        chk("bp_old_line_held", refill_icache_data_o[511:448], last_line[511:448]);
        do_req(5, exp_req_addr(64'h8000_4040), "bp");
        do_beats(exp_start(64'h8000_4040), 64'h2222_0000_0000_0000, 0, 0, 7, -1, "bp");
    endtask

    task automatic test_bubbles();
        run_miss(64'h8000_2000, 0, 64'h3333_0000_0000_0000, 1, 3, 7, -1, "bub");
        chk("bub_err", {63'b0, proto_err_o}, 64'd0);
        tick();
        chk("bub_single_pulse", {63'b0, refill_icache_valid_o}, 64'd0);
    endtask

    task automatic test_proto_miss();
        run_miss(64'h8000_3000, 1, 64'h4444_0000_0000_0000, 0, 0, 7, 2, "pmiss");
        chk("pmiss_err", {63'b0, proto_err_o}, 64'd1);
        chk("pmiss_no_reissue", {63'b0, mem_req_valid_o}, 64'd0);
    endtask

    task automatic test_proto_last();
        do_reset();
        chk("plast_err_cleared", {63'b0, proto_err_o}, 64'd0);
        run_miss(64'h8000_5000, 0, 64'h5555_0000_0000_0000, 0, 0, 3, -1, "plast");
        chk("plast_err", {63'b0, proto_err_o}, 64'd1);
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_miss(64'h8000_6000, "rmid");
        do_req(0, exp_req_addr(64'h8000_6000), "rmid");
        for (int i = 0; i < 4; i++) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = 64'h6666_0000_0000_0000 + 64'(i);
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_busy", {63'b0, busy_o}, 64'd0);
        chk("rmid_refill_valid", {63'b0, refill_icache_valid_o}, 64'd0);
        chk("rmid_data", refill_icache_data_o[63:0], 64'd0);
        chk("rmid_req_addr", mem_req_addr_o, 64'd0);
        chk("rmid_err_clear", {63'b0, proto_err_o}, 64'd0);
        tick();
        chk("rmid_no_pulse", {63'b0, refill_icache_valid_o}, 64'd0);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = 64'hBAD0;
        tick();
        mem_rsp_valid_i = 1'b0;
        chk("rmid_stray_err", {63'b0, proto_err_o}, 64'd1);
        chk("rmid_stray_ignored", {63'b0, busy_o}, 64'd0);
        run_miss(64'h8000_7000, 0, 64'h7777_0000_0000_0000, 0, 0, 7, -1, "rmid_new");
    endtask

    task automatic test_cwf();
        do_reset();
        run_miss(64'h8000_1228, 0, 64'h8888_0000_0000_0000, 0, 0, 7, -1, "cwf");
        chk("cwf_err", {63'b0, proto_err_o}, 64'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_proto_miss();
        test_proto_last();
        test_reset_mid();
        test_cwf();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
